fc_in_buffer: RTL and testbench
===============================

Name: fc_in_buffer

Overview:
Upstream feeder for the combinational fully-connected neuron `layer` (WIDTH-bit activations in, ReLU'd sum out).
- Deserialises a valid/ready stream of IN activations into a stable IN-entry vector driving `layer.x`.
- Holds the vector for SETTLE cycles so the multiplier/adder tree settles.
- Registers `layer.z` and presents it downstream on a valid/ready output.
- Turns the purely combinational neuron into a streaming pipeline stage.

Parameters:
- WIDTH, 8, activation bit width (same as `layer` WIDTH).
- IN, 128, activations per frame (same as `layer` IN).
- Z_WIDTH, 23, width of `layer` result, WIDTH*2+$clog2(IN) at defaults.
- SETTLE, 2, cycles the vector is held before z is sampled; legal range 1..15.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid&&s_ready.
- s_data  in  WIDTH  activation value.
- s_last  in  1  marks final beat of a frame.
- x  out  WIDTH x [0:IN-1]  registered activation vector to `layer.x`.
- z_in  in  Z_WIDTH  combinational result from `layer.z`.
- m_valid  out  1  result valid.
- m_ready  in  1  downstream accepts result.
- m_data  out  Z_WIDTH  registered result.
- err  out  1  sticky frame-length error.

Behaviour:
- Reset (async, rst_n=0): state=FILL, cnt=0, all x entries=0, m_valid=0, m_data=0, err=0.
  - s_ready=1 from the first edge after rst_n deasserts.
  - Reset mid-frame discards partial data; no output is produced.
- States: FILL, SETTLE, OUT. s_ready = (state==FILL), combinational from state only.
- FILL, on accepted beat:
  - x[cnt]<=s_data; cnt<=cnt+1.
  - Normal end: beat with cnt==IN-1 -> state SETTLE, timer<=SETTLE-1.
    - If s_last=0 on that beat: err<=1, frame still completes. The next beat starts a new frame.
  - Short frame: beat with s_last=1 and cnt<IN-1 -> err<=1.
    - Same edge: x[cnt+1..IN-1]<=0, state SETTLE.
- SETTLE:
  - x held constant.
  - timer decrements each cycle; when timer==0: m_data<=z_in, m_valid<=1, state OUT.
- OUT:
  - m_valid and m_data hold until m_ready=1.
  - On handshake edge: m_valid<=0, cnt<=0, state FILL.
  - m_valid never drops without a handshake.
- Timing:
  - Final beat accepted at edge k -> m_valid=1 after edge k+SETTLE; z_in is sampled at that edge.
  - m_ready high while m_valid=1 at edge j -> s_ready=1 after edge j.
  - Minimum frame period: IN+SETTLE+1 cycles.
- Width rules:
  - m_data is z_in unmodified; no truncation or sign extension.
  - cnt is $clog2(IN) bits.
  - No wrap is possible, since the normal and short-frame ends both exit FILL.
- Simultaneous events:
  - s_valid during SETTLE/OUT is ignored (s_ready=0); the upstream must hold the beat.
  - m_ready asserted with m_valid=0 has no effect.
- err is cleared only by reset.

Test Plan:
1. Nominal frame, `layer` model connected, SETTLE=2: s_data=1..128 streamed back-to-back, s_last on beat 128, m_ready=1.
   -> m_valid high exactly 2 cycles after last accept, m_data = model(x), err=0, s_ready=0 for 3 cycles.
2. Backpressure: m_ready=0 for 10 cycles after m_valid rises.
   -> m_data stable, s_ready=0 throughout; 1 cycle after m_ready=1, s_ready=1.
3. Short frame: 5 beats of 0x7F with s_last on beat 5.
   -> x[0..4]=0x7F, x[5..127]=0, err=1, result emitted normally.
4. Missing s_last: 128 beats, s_last=0 throughout.
   -> err=1, result emitted; next 128-beat frame with s_last processed, err stays 1.
5. Gapped input: s_valid toggled randomly at 50%.
   -> x identical to back-to-back case, m_data identical.
6. Reset mid-operation: rst_n=0 after 60 beats, and again during OUT.
   -> immediate m_valid=0, x all 0, err=0, cnt=0. A subsequent full frame produces the correct result.

Source files
------------

// File: rtl/fc_in_buffer.sv
// Streaming front end for the combinational fully-connected neuron: collects a frame of
// activations into a held vector, waits for the neuron to settle, and registers its result.
module fc_in_buffer #(
  parameter int WIDTH   = 8,
  parameter int IN      = 128,
  parameter int Z_WIDTH = WIDTH * 2 + $clog2(IN),
  parameter int SETTLE  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [WIDTH-1:0]   s_data,
  input  logic               s_last,
  output logic [WIDTH-1:0]   x [0:IN-1],
  input  logic [Z_WIDTH-1:0] z_in,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [Z_WIDTH-1:0] m_data,
  output logic               err
);

  localparam int CW = (IN > 1) ? $clog2(IN) : 1;
  localparam int TW = 4;
  localparam logic [CW-1:0] CNT_LAST = CW'(IN - 1);
  localparam logic [TW-1:0] TMR_INIT = TW'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_OUT    = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [WIDTH-1:0]   x_q [0:IN-1];
  logic [WIDTH-1:0]   x_d [0:IN-1];
  logic               m_valid_q, m_valid_d;
  logic [Z_WIDTH-1:0] m_data_q, m_data_d;
  logic               err_q, err_d;
  logic               accept_s;
  logic               short_s;

  assign accept_s = s_valid && (state_q == ST_FILL);
  assign short_s  = s_last && (cnt_q != CNT_LAST);

  // Vector update: write the accepted beat, and zero the unfilled tail when a frame ends early.
  always_comb begin
    for (int i = 0; i < IN; i++) begin
      if (accept_s && (CW'(i) == cnt_q)) begin
        x_d[i] = s_data;
      end else if (accept_s && short_s && (CW'(i) > cnt_q)) begin
        x_d[i] = '0;
      end else begin
        x_d[i] = x_q[i];
      end
    end
  end

  // Control: frame collection, settle countdown and output handshake.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timer_d   = timer_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    err_d     = err_q;
    case (state_q)
      ST_FILL: begin
        if (s_valid) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = ST_SETTLE;
            timer_d = TMR_INIT;
            err_d   = err_q | ~s_last;
          end else if (s_last) begin
            state_d = ST_SETTLE;
            timer_d = TMR_INIT;
            err_d   = 1'b1;
          end else begin
            state_d = ST_FILL;
          end
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_SETTLE: begin
        if (timer_q == '0) begin
          m_data_d  = z_in;
          m_valid_d = 1'b1;
          state_d   = ST_OUT;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      ST_OUT: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          cnt_d     = '0;
          state_d   = ST_FILL;
        end else begin
          state_d = ST_OUT;
        end
      end
      default: begin
        state_d   = ST_FILL;
        cnt_d     = '0;
        m_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FILL;
      cnt_q     <= '0;
      timer_q   <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < IN; i++) begin
        x_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timer_q   <= timer_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      err_q     <= err_d;
      for (int i = 0; i < IN; i++) begin
        x_q[i] <= x_d[i];
      end
    end
  end

  assign s_ready = (state_q == ST_FILL);
  assign x       = x_q;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign err     = err_q;

endmodule

// File: tb/tb_fc_in_buffer.sv
// Randomised bench for fc_in_buffer: a frame-level reference model predicts every output each
// cycle; a stand-in neuron (weighted sum) drives z_in from the DUT's vector.
module tb_fc_in_buffer;
  localparam int WIDTH = 8, IN = 128, ZW = 23, SETTLE = 2;

  logic             clk = 1'b0, rst_n = 1'b0;
  logic             s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b0;
  logic [WIDTH-1:0] s_data = '0;
  logic             s_ready, m_valid, err;
  logic [ZW-1:0]    z_in, m_data;
  logic [WIDTH-1:0] x_w [0:IN-1];

  int checks = 0, errors = 0;

  // model state
  logic [WIDTH-1:0] mdl_x [0:IN-1];
  int               cnt_m, cyc, ready_at;
  bit               busy, mdl_err;
  logic [ZW-1:0]    cur_z, prev_md;

  fc_in_buffer #(.WIDTH(WIDTH), .IN(IN), .Z_WIDTH(ZW), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .x(x_w), .z_in(z_in), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .err(err)
  );

  always #5 clk = ~clk;

  // Stand-in neuron: sum of x[i] * ((i mod 4) + 1), always non-negative so ReLU is identity.
  function automatic logic [ZW-1:0] layer_model(input logic [WIDTH-1:0] v [0:IN-1]);
    int acc = 0;
    for (int i = 0; i < IN; i++) acc += int'(v[i]) * ((i % 4) + 1);
    return ZW'(acc);
  endfunction

  always_comb z_in = layer_model(x_w);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks frames as lists of accepted beats and predicts results and timing.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        busy = 0; mdl_err = 0; cnt_m = 0; cyc = 0; ready_at = 0;
        cur_z = '0; prev_md = '0;
        for (int i = 0; i < IN; i++) mdl_x[i] = '0;
      end else begin
        cyc++;
        if (busy) begin
          if (cyc > ready_at && m_ready) begin
            busy = 0;
            prev_md = cur_z;
          end
        end else if (s_valid) begin
          mdl_x[cnt_m] = s_data;
          cnt_m++;
          if (cnt_m == IN || s_last) begin
            if ((cnt_m == IN) != s_last) mdl_err = 1;
            for (int i = cnt_m; i < IN; i++) mdl_x[i] = '0;
            cur_z = layer_model(mdl_x);
            busy = 1;
            ready_at = cyc + SETTLE;
            cnt_m = 0;
          end
        end
      end
    end
  end

  // Compare every cycle on the falling edge.
  initial begin
    forever begin
      int bad;
      bit ev;
      @(negedge clk);
      ev = busy && (cyc >= ready_at);
      if (rst_n) chk("s_ready", s_ready, !busy);
      chk("m_valid", m_valid, ev);
      chk("m_data", m_data, ev ? cur_z : prev_md);
      chk("err", err, mdl_err);
      bad = 0;
      for (int i = 0; i < IN; i++) if (x_w[i] !== mdl_x[i]) bad++;
      chk("x_vec_mismatches", bad, 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode: 0 = 1,2,3..., 1 = 0x7F, 2 = random. mr_pct: chance m_ready is high per cycle.
  task automatic send_frame(input int n, input bit last_flag, input int vpct, input int mode,
                            input int mr_pct);
    int i = 0, guard = 0;
    logic [WIDTH-1:0] cur;
    bit acc;
    cur = (mode == 0) ? 8'd1 : (mode == 1) ? 8'h7F : 8'($urandom);
    while (i < n && guard < 5000) begin
      s_valid = ($urandom_range(0, 99) < vpct);
      s_data  = cur;
      s_last  = last_flag && (i == n - 1);
      m_ready = ($urandom_range(0, 99) < mr_pct);
      acc = s_valid && s_ready;
      step();
      guard++;
      if (acc) begin
        i++;
        cur = (mode == 0) ? 8'(i + 1) : (mode == 1) ? 8'h7F : 8'($urandom);
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (i < n) chk("send_timeout", 64'(i), 64'(n));
  endtask

  task automatic wait_mvalid(output int n);
    n = 0;
    while (!m_valid && n < 100) begin
      step();
      n++;
    end
    if (!m_valid) chk("mvalid_timeout", 64'(m_valid), 64'd1);
  endtask

  task automatic drain();
    int g = 0;
    m_ready = 1'b1;
    while (!s_ready && g < 100) begin
      step();
      g++;
    end
    if (!s_ready) chk("drain_timeout", 64'(s_ready), 64'd1);
  endtask

  initial begin
    int lat;
    repeat (3) step();
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    step();

    // nominal frame: sum over k of (40k+30), k=0..31 = 20800
    send_frame(IN, 1, 100, 0, 100);
    wait_mvalid(lat);
    chk("t1_latency", lat, SETTLE);
    chk("t1_m_data", m_data, 20800);
    chk("t1_err", err, 0);

    // backpressure
    drain();
    send_frame(IN, 1, 100, 0, 0);
    wait_mvalid(lat);
    repeat (10) step();
    chk("t2_m_data_held", m_data, 20800);
    chk("t2_s_ready_low", s_ready, 0);
    m_ready = 1'b1;
    step();
    chk("t2_s_ready_after", s_ready, 1);

    // short frame: 127 * (1+2+3+4+1) = 1397
    drain();
    send_frame(5, 1, 100, 1, 100);
    wait_mvalid(lat);
    chk("t3_m_data", m_data, 1397);
    chk("t3_err", err, 1);
    chk("t3_x4", x_w[4], 8'h7F);
    chk("t3_x5", x_w[5], 0);
    chk("t3_x127", x_w[127], 0);

    // missing s_last, then a good frame; err stays set
    drain();
    send_frame(IN, 0, 100, 0, 100);
    wait_mvalid(lat);
    chk("t4_err", err, 1);
    drain();
    send_frame(IN, 1, 100, 0, 100);
    wait_mvalid(lat);
    chk("t4_m_data", m_data, 20800);
    chk("t4_err_sticky", err, 1);

    // gapped input
    drain();
    send_frame(IN, 1, 50, 0, 100);
    wait_mvalid(lat);
    chk("t5_m_data", m_data, 20800);

    // reset mid-fill
    drain();
    send_frame(60, 0, 100, 0, 100);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_m_valid", m_valid, 0);
    chk("t6_rst_err", err, 0);
    chk("t6_rst_x0", x_w[0], 0);
    step();
    rst_n = 1'b1;
    step();
    send_frame(IN, 1, 100, 0, 100);
    wait_mvalid(lat);
    chk("t6_m_data", m_data, 20800);
    chk("t6_err", err, 0);

    // reset during OUT
    drain();
    send_frame(IN, 1, 100, 0, 0);
    wait_mvalid(lat);
    step();
    rst_n = 1'b0;
    #1;
    chk("t6b_rst_m_valid", m_valid, 0);
    chk("t6b_rst_m_data", m_data, 0);
    step();
    rst_n = 1'b1;
    step();

    // random frames
    for (int f = 0; f < 30; f++) begin
      int len;
      len = $urandom_range(1, IN);
      send_frame(len, (len < IN) ? 1'b1 : 1'($urandom_range(0, 1)),
                 $urandom_range(30, 100), $urandom_range(0, 2), 50);
    end
    drain();
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
